// File: rtl/sdram_bist_pkg.sv
// Shared types, mode encodings and the test-pattern function for the SDRAM BIST.
package sdram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [1:0] MODE_ADDR_INV = 2'd0;  // {~A, A}
  localparam logic [1:0] MODE_ADDR_DUP = 2'd1;  // {A, A}
  localparam logic [1:0] MODE_CHECKER  = 2'd2;  // alternating 5555AAAA / AAAA5555
  localparam logic [1:0] MODE_STRIPE   = 2'd3;  // alternating all-zero / all-one

  localparam logic [31:0] PAT_55AA = 32'h5555AAAA;
  localparam logic [31:0] PAT_AA55 = 32'hAAAA5555;

  // Word expected at address a (already zero-extended to 16 bits) for a given mode.
  function automatic logic [31:0] pattern(input logic [15:0] a, input logic [1:0] mode);
    logic [31:0] p;
    case (mode)
      MODE_ADDR_INV: p = {~a, a};
      MODE_ADDR_DUP: p = {a, a};
      MODE_CHECKER:  p = a[0] ? PAT_AA55 : PAT_55AA;
      MODE_STRIPE:   p = a[0] ? 32'hFFFF_FFFF : 32'h0000_0000;
      default:       p = 32'h0000_0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sdram_bist_pattern.sv
// Combinational pattern generator; one instance serves as both write data and compare value.
module sdram_bist_pattern
  import sdram_bist_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        mode_i,
  output logic [31:0]       data_o
);

  // Zero-extend the word address and look up the pattern.
  assign data_o = pattern(16'(addr_i), mode_i);

endmodule

// File: rtl/sdram_bist.sv
// SDRAM BIST sequencer: writes a pattern to every word, reads each back and compares.
// Drives the controller request port directly; one request outstanding at a time.
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              timeout_o,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [31:0]       err_data_o,
  output logic              phase_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       data_o,
  output logic              req_o,
  output logic              we_o,
  input  logic              ack_i,
  input  logic              valid_i,
  input  logic [31:0]       q_i
);

  // Counters are loaded with N-1 so that terminal count 0 marks the last cycle.
  localparam logic [15:0] GAP_LOAD = (GAP > 0) ? 16'(GAP - 1) : 16'd0;
  localparam logic [15:0] TO_LOAD  = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;
  localparam bit          NO_GAP   = (GAP == 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [1:0]        mode_q, mode_d;
  logic              phase_q, phase_d, req_q, req_d, we_q, we_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, timeout_q, timeout_d;
  logic [15:0]       err_count_q, err_count_d, gap_cnt_q, gap_cnt_d, to_cnt_q, to_cnt_d;
  logic [31:0]       err_data_q, err_data_d, pat;
  logic              last_addr, rd_ack, rd_hit, rd_to, rd_done, rd_err;
  state_e            rd_next;

  sdram_bist_pattern #(.ADDR_W(ADDR_W)) u_pattern (
    .addr_i (addr_q),
    .mode_i (mode_q),
    .data_o (pat)
  );

  // A read resolves either on valid (possibly together with its ack) or on timeout.
  assign last_addr = &addr_q;
  assign rd_ack    = (state_q == S_RD) && req_q && ack_i;
  assign rd_hit    = (rd_ack && valid_i) || ((state_q == S_RD_WAIT) && valid_i);
  assign rd_to     = (state_q == S_RD_WAIT) && !valid_i && (to_cnt_q == 16'd0);
  assign rd_done   = rd_hit || rd_to;
  assign rd_err    = rd_to || (rd_hit && (q_i != pat));
  assign rd_next   = last_addr ? S_DONE : (NO_GAP ? S_RD : S_GAP);

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = S_WR;
      S_WR: begin
        if (req_q && ack_i) begin
          if (!NO_GAP)        state_d = S_GAP;
          else if (last_addr) state_d = S_RD;
        end
      end
      S_RD, S_RD_WAIT: begin
        if (rd_done)     state_d = rd_next;
        else if (rd_ack) state_d = S_RD_WAIT;
      end
      S_GAP: if (gap_cnt_q == 16'd0) state_d = phase_q ? S_RD : S_WR;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    addr_d      = addr_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    req_d       = req_q;
    we_d        = we_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    timeout_d   = timeout_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    err_data_d  = err_data_q;
    gap_cnt_d   = gap_cnt_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          addr_d      = '0;
          phase_d     = 1'b0;
          mode_d      = mode_i;
          req_d       = 1'b1;
          we_d        = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          timeout_d   = 1'b0;
          err_count_d = '0;
          err_addr_d  = '0;
          err_data_d  = '0;
        end
      end
      S_WR: begin
        // With no gap configured we land here with req low for one cycle.
        if (!req_q) begin
          req_d = 1'b1;
          we_d  = 1'b1;
        end else if (ack_i) begin
          req_d     = 1'b0;
          we_d      = 1'b0;
          gap_cnt_d = GAP_LOAD;
          if (last_addr) begin
            addr_d  = '0;
            phase_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_RD: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (ack_i) begin
          req_d    = 1'b0;
          to_cnt_d = TO_LOAD;
        end
      end
      S_RD_WAIT: if (!valid_i && (to_cnt_q != 16'd0)) to_cnt_d = to_cnt_q - 16'd1;
      S_GAP: begin
        if (gap_cnt_q == 16'd0) begin
          req_d = 1'b1;
          we_d  = ~phase_q;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: ;
    endcase
    if (rd_done) begin
      if (rd_err) begin
        err_d = 1'b1;
        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        if (!err_q) begin
          err_addr_d = addr_q;
          err_data_d = rd_to ? 32'h0 : q_i;
        end
      end
      if (rd_to) timeout_d = 1'b1;
      if (last_addr) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        addr_d    = addr_q + ADDR_W'(1);
        gap_cnt_d = GAP_LOAD;
      end
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q      <= '0;
      phase_q     <= 1'b0;
      mode_q      <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
    end else begin
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      req_q       <= req_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      err_data_q  <= err_data_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Write data is forced to zero outside a pass so every output idles at 0.
  assign data_o      = busy_q ? pat : 32'h0;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign timeout_o   = timeout_q;
  assign err_count_o = err_count_q;
  assign err_addr_o  = err_addr_q;
  assign err_data_o  = err_data_q;
  assign phase_o     = phase_q;
  assign addr_o      = addr_q;
  assign req_o       = req_q;
  assign we_o        = we_q;

endmodule

// File: tb/tb_sdram_bist.sv
// Self-checking bench for sdram_bist: a GAP=1/TIMEOUT=8 instance against a slow memory
// model and a GAP=0 instance against a memory answering ack+valid in the same cycle.
module tb_sdram_bist;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance signals.
  logic        start = 1'b0, busy, done, err, tmo, phase, req, we;
  logic        ack = 1'b0, valid = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] err_count;
  logic [3:0]  err_addr, addr;
  logic [31:0] err_data, data, q = 32'h0;

  // GAP=0 instance signals.
  logic        start0 = 1'b0, busy0, done0, err0, tmo0, phase0, req0, we0;
  logic        ack0 = 1'b0, valid0 = 1'b0;
  logic [1:0]  mode0 = 2'd0;
  logic [15:0] err_count0;
  logic [3:0]  err_addr0, addr0;
  logic [31:0] err_data0, data0, q0 = 32'h0;

  sdram_bist #(.ADDR_W(4), .GAP(1), .TIMEOUT(8)) u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .mode_i(mode),
    .busy_o(busy), .done_o(done), .err_o(err), .timeout_o(tmo),
    .err_count_o(err_count), .err_addr_o(err_addr), .err_data_o(err_data),
    .phase_o(phase), .addr_o(addr), .data_o(data), .req_o(req), .we_o(we),
    .ack_i(ack), .valid_i(valid), .q_i(q)
  );

  sdram_bist #(.ADDR_W(4), .GAP(0), .TIMEOUT(8)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start0), .mode_i(mode0),
    .busy_o(busy0), .done_o(done0), .err_o(err0), .timeout_o(tmo0),
    .err_count_o(err_count0), .err_addr_o(err_addr0), .err_data_o(err_data0),
    .phase_o(phase0), .addr_o(addr0), .data_o(data0), .req_o(req0), .we_o(we0),
    .ack_i(ack0), .valid_i(valid0), .q_i(q0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference pattern from plain arithmetic on the address value.
  function automatic logic [31:0] exp_pat(input int a, input int m);
    longint v;
    case (m)
      0:       v = longint'(65535 - a) * 65536 + longint'(a);
      1:       v = longint'(a) * 65537;
      2:       v = (a % 2 == 1) ? 64'hAAAA5555 : 64'h5555AAAA;
      default: v = (a % 2 == 1) ? 64'hFFFFFFFF : 64'h0;
    endcase
    return v[31:0];
  endfunction

  // Slow memory: ack on the second cycle of a request, read data 3 cycles after ack.
  logic [31:0] mem [16];
  int          age = 0, vcnt = 0, rd_a = 0, n_wr = 0, n_rd = 0, cur_mode = 0;
  int          corrupt_addr = -1, drop_addr = -1;
  bit          corrupt_all = 1'b0;
  logic [31:0] flip = 32'h20;

  always @(negedge clk) begin
    if (reset) begin
      ack = 1'b0; valid = 1'b0; q = 32'h0; age = 0; vcnt = 0;
    end else begin
      ack = 1'b0; valid = 1'b0;
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) begin
          valid = 1'b1;
          q = mem[rd_a];
          if (rd_a == corrupt_addr || corrupt_all) q = q ^ flip;
        end
      end
      if (req) begin
        age++;
        if (age == 2) begin
          ack = 1'b1;
          if (we) begin
            mem[addr] = data;
            n_wr++;
            chk("wr_data", data, exp_pat(int'(addr), cur_mode));
          end else begin
            rd_a = int'(addr);
            n_rd++;
            if (rd_a != drop_addr) vcnt = 3;
          end
        end
      end else begin
        age = 0;
      end
    end
  end

  // Fast memory: ack (and valid for reads) in the first cycle of every request.
  logic [31:0] mem0 [16];
  int          n_rd0 = 0, low0 = 0, cur_mode0 = 0;
  bit          seen0 = 1'b0, corrupt0_all = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      ack0 = 1'b0; valid0 = 1'b0; q0 = 32'h0; seen0 = 1'b0; low0 = 0;
    end else begin
      ack0 = 1'b0; valid0 = 1'b0;
      if (req0) begin
        if (seen0) chk("gap0_req_low_cycles", low0, 1);
        seen0 = 1'b1; low0 = 0; ack0 = 1'b1;
        if (we0) begin
          mem0[addr0] = data0;
          chk("wr0_data", data0, exp_pat(int'(addr0), cur_mode0));
        end else begin
          valid0 = 1'b1;
          q0 = mem0[addr0] ^ (corrupt0_all ? 32'h1 : 32'h0);
          n_rd0++;
        end
      end else begin
        low0++;
        if (!busy0) seen0 = 1'b0;
      end
    end
  end

  task automatic start_pass(input int m);
    @(negedge clk);
    mode = 2'(m); cur_mode = m; n_wr = 0; n_rd = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    chk("done_reached", done, 1);
    chk("busy_low_at_done", busy, 0);
  endtask

  task automatic run_pass0(input int m);
    int n = 0;
    @(negedge clk);
    mode0 = 2'(m); cur_mode0 = m; n_rd0 = 0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (!done0 && n < 3000) begin @(negedge clk); n++; end
    chk("g0_done_reached", done0, 1);
    chk("g0_reads", n_rd0, 16);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    // Reset values.
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_err", err, 0);        chk("rst_timeout", tmo, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_data", err_data, 0);
    chk("rst_phase", phase, 0);    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);      chk("rst_req", req, 0);
    chk("rst_we", we, 0);
    reset = 1'b0;

    // Clean pass, mode 0, with a start pulse while busy that must be ignored.
    start_pass(0);
    n = 0;
    while (!(phase && addr == 4'd4) && n < 3000) begin @(negedge clk); n++; end
    chk("reach_read_addr4", {phase, addr}, {1'b1, 4'd4});
    mode = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_busy", busy, 1);
    wait_done();
    chk("clean_err", err, 0);
    chk("clean_err_count", err_count, 0);
    chk("clean_writes", n_wr, 16);
    chk("clean_reads", n_rd, 16);
    chk("clean_word3", mem[3], 32'hFFFC0003);
    chk("clean_addr_hold", addr, 15);

    // Bit 5 of word 7 corrupted on read.
    corrupt_addr = 7; flip = 32'h20;
    start_pass(0);
    wait_done();
    chk("cor7_err", err, 1);
    chk("cor7_count", err_count, 1);
    chk("cor7_addr", err_addr, 7);
    chk("cor7_data", err_data, exp_pat(7, 0) ^ 32'h20);
    chk("cor7_timeout", tmo, 0);
    corrupt_addr = -1;

    // No valid for address 2: timeout, then the pass continues.
    drop_addr = 2;
    start_pass(1);
    wait_done();
    chk("to_timeout", tmo, 1);
    chk("to_err", err, 1);
    chk("to_count", err_count, 1);
    chk("to_addr", err_addr, 2);
    chk("to_data", err_data, 0);
    chk("to_reads", n_rd, 16);
    drop_addr = -1;

    // Every read corrupted with the count preloaded one below saturation.
    corrupt_all = 1'b1;
    start_pass(3);
    force u_dut.err_count_q = 16'hFFFE;
    #1;
    release u_dut.err_count_q;
    wait_done();
    chk("sat_count", err_count, 16'hFFFF);
    chk("sat_addr", err_addr, 0);
    chk("sat_data", err_data, exp_pat(0, 3) ^ 32'h20);
    corrupt_all = 1'b0;

    // Randomized passes: random mode, optional single corrupted word and bit.
    for (int i = 0; i < 4; i++) begin
      int m, ca;
      logic [31:0] f;
      m  = int'($urandom_range(0, 3));
      ca = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 15));
      f  = 32'h1 << $urandom_range(0, 31);
      corrupt_addr = ca; flip = f;
      start_pass(m);
      wait_done();
      chk("rnd_err", err, (ca >= 0) ? 1 : 0);
      chk("rnd_count", err_count, (ca >= 0) ? 1 : 0);
      if (ca >= 0) begin
        chk("rnd_addr", err_addr, ca);
        chk("rnd_data", err_data, exp_pat(ca, m) ^ f);
      end
    end
    corrupt_addr = -1; flip = 32'h20;

    // GAP=0 with same-cycle ack+valid: clean pass, then all reads corrupted.
    run_pass0(int'($urandom_range(0, 3)));
    chk("g0_clean_count", err_count0, 0);
    chk("g0_clean_err", err0, 0);
    corrupt0_all = 1'b1;
    run_pass0(2);
    chk("g0_cor_count", err_count0, 16);
    chk("g0_cor_addr", err_addr0, 0);
    chk("g0_cor_data", err_data0, exp_pat(0, 2) ^ 32'h1);
    chk("g0_cor_timeout", tmo0, 0);
    chk("g0_cor_phase", phase0, 1);
    corrupt0_all = 1'b0;

    // Reset during the read of address 9, then a clean pass.
    corrupt_addr = 3;
    start_pass(1);
    n = 0;
    while (!(phase && addr == 4'd9 && req) && n < 3000) begin @(negedge clk); n++; end
    chk("reach_read_addr9", {phase, addr, req}, {1'b1, 4'd9, 1'b1});
    chk("pre_reset_count", err_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_count", err_count, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_data", data, 0);
    @(negedge clk);
    reset = 1'b0;
    corrupt_addr = -1;
    start_pass(2);
    wait_done();
    chk("post_rst_err", err, 0);
    chk("post_rst_count", err_count, 0);
    chk("post_rst_reads", n_rd, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
